// File: rtl/fetch_redirect_if.sv
// fetch_redirect_if: bundle between the execute stage, the fetch redirect
// unit and the PC block. The execute side (master) drives the resolution
// inputs and observes the redirect outputs. The redirect unit is the slave.
// Optional macro FETCH_REDIRECT_PERF_CNT_EN adds two performance counters.
interface fetch_redirect_if #(
    parameter int PC_WIDTH  = 32,
    parameter int CNT_WIDTH = 32
);
    // Execute-stage resolution
    logic                ex_valid_in;
    logic                ex_is_branch_in;
    logic                ex_is_jal_in;
    logic                ex_is_jalr_in;
    logic                ex_br_taken_in;
    logic [PC_WIDTH-1:0] ex_target_in;

    // Redirect towards PC / fetch
    logic                pc_sel_out;
    logic [PC_WIDTH-1:0] pc_new_out;
    logic                flush_out;
    logic                misalign_out;
    logic                busy_out;

`ifdef FETCH_REDIRECT_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] redirect_cnt_out;
    logic [CNT_WIDTH-1:0] flush_cnt_out;

    modport master (
        output ex_valid_in, ex_is_branch_in, ex_is_jal_in, ex_is_jalr_in,
               ex_br_taken_in, ex_target_in,
        input  pc_sel_out, pc_new_out, flush_out, misalign_out, busy_out,
               redirect_cnt_out, flush_cnt_out
    );

    modport slave (
        input  ex_valid_in, ex_is_branch_in, ex_is_jal_in, ex_is_jalr_in,
               ex_br_taken_in, ex_target_in,
        output pc_sel_out, pc_new_out, flush_out, misalign_out, busy_out,
               redirect_cnt_out, flush_cnt_out
    );
`else
    modport master (
        output ex_valid_in, ex_is_branch_in, ex_is_jal_in, ex_is_jalr_in,
               ex_br_taken_in, ex_target_in,
        input  pc_sel_out, pc_new_out, flush_out, misalign_out, busy_out
    );

    modport slave (
        input  ex_valid_in, ex_is_branch_in, ex_is_jal_in, ex_is_jalr_in,
               ex_br_taken_in, ex_target_in,
        output pc_sel_out, pc_new_out, flush_out, misalign_out, busy_out
    );
`endif

endinterface : fetch_redirect_if

// File: rtl/fetch_redirect_unit.sv
// fetch_redirect_unit: resolves execute-stage branches/jumps into a
// registered one-cycle PC redirect pulse. After each redirect it raises
// flush_out for FLUSH_DEPTH cycles so wrong-path instructions are killed.
// Requests that arrive while a redirect/flush is in progress are wrong-path
// and are ignored. A target with bit 1 set is reported on misalign_out
// instead of being redirected to.
// Optional macro FETCH_REDIRECT_PERF_CNT_EN adds saturating redirect and
// flush-cycle counters.
module fetch_redirect_unit #(
    parameter int PC_WIDTH    = 32,
    parameter int FLUSH_DEPTH = 3,   // 1..15
    parameter int CNT_WIDTH   = 32
) (
    input  logic               clk,
    input  logic               rst,
    fetch_redirect_if.slave    bus
);

    localparam int FC_WIDTH = 4;
    localparam logic [FC_WIDTH-1:0] FLUSH_LOAD = FC_WIDTH'(FLUSH_DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_REDIRECT = 2'd1,
        S_FLUSH    = 2'd2
    } state_e;

    state_e                state_q;
    logic                  pc_sel_q;
    logic [PC_WIDTH-1:0]   pc_new_q;
    logic                  flush_q;
    logic                  misalign_q;
    logic [FC_WIDTH-1:0]   flush_cnt_q;

    logic [PC_WIDTH-1:0]   eff_tgt;
    logic                  is_cf;
    logic                  req;

    // Effective target and redirect request from the execute stage.
    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        eff_tgt = bus.ex_target_in;
        // JALR has priority over JAL/branch and always clears bit 0.
        if (bus.ex_is_jalr_in) begin
            eff_tgt[0] = 1'b0;
        end
        is_cf = bus.ex_is_jalr_in
              | bus.ex_is_jal_in
              | (bus.ex_is_branch_in & bus.ex_br_taken_in);
        req   = bus.ex_valid_in & is_cf & (state_q == S_IDLE);
    end

    // Redirect FSM with registered outputs: IDLE -> REDIRECT -> FLUSH -> IDLE.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            pc_sel_q    <= 1'b0;
            pc_new_q    <= '0;
            flush_q     <= 1'b0;
            misalign_q  <= 1'b0;
            flush_cnt_q <= '0;
        end else begin
            // Misalignment is a single-cycle pulse.
            misalign_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    pc_sel_q <= 1'b0;
                    flush_q  <= 1'b0;
                    if (req) begin
                        if (eff_tgt[1]) begin
                            // Misaligned target: report it, no redirect.
                            misalign_q <= 1'b1;
                        end else begin
                            state_q     <= S_REDIRECT;
                            pc_sel_q    <= 1'b1;
                            pc_new_q    <= eff_tgt;
                            flush_q     <= 1'b1;
                            flush_cnt_q <= FLUSH_LOAD;
                        end
                    end
                end
                S_REDIRECT: begin
                    // Redirect pulse lasts exactly one cycle. pc_new_q holds.
                    pc_sel_q <= 1'b0;
                    if (FLUSH_DEPTH > 1) begin
                        state_q <= S_FLUSH;
                        flush_q <= 1'b1;
                    end else begin
                        state_q <= S_IDLE;
                        flush_q <= 1'b0;
                    end
                end
                S_FLUSH: begin
                    pc_sel_q    <= 1'b0;
                    flush_cnt_q <= flush_cnt_q - 1'b1;
                    // Counter reaching one marks the last flush cycle.
                    if (flush_cnt_q <= FC_WIDTH'(1)) begin
                        state_q     <= S_IDLE;
                        flush_q     <= 1'b0;
                        flush_cnt_q <= '0;
                    end else begin
                        flush_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    pc_sel_q    <= 1'b0;
                    flush_q     <= 1'b0;
                    flush_cnt_q <= '0;
                end
            endcase
        end
    end

    assign bus.pc_sel_out   = pc_sel_q;
    assign bus.pc_new_out   = pc_new_q;
    assign bus.flush_out    = flush_q;
    assign bus.misalign_out = misalign_q;
    assign bus.busy_out     = (state_q != S_IDLE);

`ifdef FETCH_REDIRECT_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] redirect_cnt_q;
    logic [CNT_WIDTH-1:0] flush_cyc_cnt_q;

    // Saturating perf counters: one count per REDIRECT entry and per flush cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            redirect_cnt_q  <= '0;
            flush_cyc_cnt_q <= '0;
        end else begin
            if ((state_q == S_REDIRECT) && (redirect_cnt_q != '1)) begin
                redirect_cnt_q <= redirect_cnt_q + 1'b1;
            end
            if (flush_q && (flush_cyc_cnt_q != '1)) begin
                flush_cyc_cnt_q <= flush_cyc_cnt_q + 1'b1;
            end
        end
    end

    assign bus.redirect_cnt_out = redirect_cnt_q;
    assign bus.flush_cnt_out    = flush_cyc_cnt_q;
`endif

endmodule : fetch_redirect_unit

// File: doc/fetch_redirect_unit.md
Name: fetch_redirect_unit

Overview:
- Control-flow resolver: accepts execute-stage branch/jump resolution and drives the PC block's select/new-value inputs (pc_sel, pc_new).
- Registers the redirect so the PC sees a clean one-cycle pulse.
- Counts off wrong-path instructions with a flush window so younger fetched instructions are killed.
- Sits between the execute stage and the PC/fetch stage.

Parameters:
- PC_WIDTH, 32, width of pc/target values.
- FLUSH_DEPTH, 3, wrong-path instructions to kill after a redirect (1..15).
- CNT_WIDTH, 32, width of perf counters (optional feature only).

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- ex_valid_in  input  1  execute stage holds a valid instruction this cycle
- ex_is_branch_in  input  1  conditional branch
- ex_is_jal_in  input  1  JAL
- ex_is_jalr_in  input  1  JALR
- ex_br_taken_in  input  1  branch condition result (used only with ex_is_branch_in)
- ex_target_in  input  PC_WIDTH  computed target from ALU
- pc_sel_out  output  1  to PC select: 1 = load pc_new_out
- pc_new_out  output  PC_WIDTH  redirect target to PC
- flush_out  output  1  kill instruction in IF/ID this cycle
- misalign_out  output  1  one-cycle pulse: redirect target misaligned
- busy_out  output  1  state != IDLE

Behaviour:
- Reset (async, rst=1): state=IDLE, pc_sel_out=0, pc_new_out=0, flush_out=0, misalign_out=0, flush counter=0. Takes effect immediately, not at the clock edge; aborts any redirect/flush in progress.
- Effective target: JALR clears bit 0 (tgt = ex_target_in & ~1); JAL/branch use ex_target_in unchanged.
- Redirect request: req = ex_valid_in & (jal | jalr | (branch & br_taken)) & (state == IDLE).
- Masking: requests while state != IDLE are wrong-path and are ignored.
- Misalignment: req with tgt[1] == 1:
  - no redirect;
  - misalign_out = 1 next cycle for exactly one cycle;
  - state stays IDLE.
- States:
  - IDLE: on aligned req at edge N -> REDIRECT. pc_sel_out=1 and pc_new_out=tgt are registered, visible cycle N+1.
  - REDIRECT: one cycle. pc_sel_out=1, flush_out=1. Counter loads FLUSH_DEPTH-1. Next state is FLUSH if FLUSH_DEPTH > 1, else IDLE.
  - FLUSH: pc_sel_out=0, flush_out=1. Counter decrements each cycle; on the cycle counter==1 -> IDLE next. Total flush_out high = FLUSH_DEPTH cycles, starting at the REDIRECT cycle.
- pc_new_out holds its last value when pc_sel_out=0; consumers must ignore it then.
- Latency: resolution cycle N -> pc_sel_out at N+1 -> new PC at N+2.
- Back-to-back: first valid request after returning to IDLE is accepted in that same cycle.
- ex_is_* one-hot; if multiple are set, priority is jalr > jal > branch.
- busy_out = (state != IDLE), combinational from state.

Optional Feature:
- Macro: FETCH_REDIRECT_PERF_CNT_EN.
- Defined: adds outputs redirect_cnt_out [CNT_WIDTH] and flush_cnt_out [CNT_WIDTH], both reset to 0.
  - redirect_cnt_out increments once per REDIRECT entry.
  - flush_cnt_out increments once per cycle with flush_out=1.
  - Both saturate at all-ones.
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan:
- Reset: assert rst mid-cycle during FLUSH -> all outputs 0 immediately, busy_out=0; release -> IDLE.
- Taken branch: ex_valid=1, branch=1, taken=1, target=0x0000_0100 at cycle 5 -> pc_sel_out=1, pc_new_out=0x100 in cycle 6 only; flush_out high cycles 6-8 (FLUSH_DEPTH=3); busy_out low cycle 9.
- Not-taken branch / invalid: branch=1, taken=0 (or ex_valid=0, jal=1) -> no pc_sel_out, no flush, busy_out stays 0.
- JALR alignment: jalr target 0x0000_0205 -> pc_new_out=0x0000_0204. Jal target 0x0000_0102 -> misalign_out pulse 1 cycle, pc_sel_out stays 0.
- Wrong-path masking: jal to 0x40 at cycle 5, another jal to 0x80 at cycle 7 (during FLUSH) -> only 0x40 issued. A jal to 0x80 at cycle 9 (IDLE) -> accepted, pc_sel_out at cycle 10.
- Perf (FETCH_REDIRECT_PERF_CNT_EN): two redirects with FLUSH_DEPTH=3 -> redirect_cnt_out=2, flush_cnt_out=6. Preload near saturation -> holds at all-ones.
